// File: rtl/booth_product_accumulator.sv
// Sums N_TERMS consecutive signed 64-bit products into an ACC_W-bit dot product,
// flags signed overflow and queues finished sums in a 2-entry output FIFO.
module booth_product_accumulator #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 72
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      prod_in,
    input  logic             prod_valid,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [7:0]       term_cnt,
    output logic             overrun,
    output logic             dbg_state
);

    // Handshake: a result transfers on any rising edge where res_valid && res_ready;
    // res_data/res_ovf are held stable while res_valid is high and res_ready is low.

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    localparam logic [7:0] LAST = 8'(N_TERMS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_run_q, ovf_run_d;
    logic             overrun_q, overrun_d;

    logic [ACC_W-1:0] head_q, head_d, tail_q, tail_d;
    logic             head_ovf_q, head_ovf_d, tail_ovf_q, tail_ovf_d;
    logic             head_v_q, head_v_d, tail_v_q, tail_v_d;

    logic signed [63:0] prod_s;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   base, sum;
    logic [7:0]         base_cnt;
    logic               base_ovf, add_ovf, accept, push, pop, push_ovf;

    assign prod_s   = $signed(prod_in);
    assign prod_ext = ACC_W'(prod_s);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_run_d = ovf_run_q;
        overrun_d = overrun_q;
        base      = acc_q;
        base_cnt  = cnt_q;
        base_ovf  = ovf_run_q;
        push      = 1'b0;
        push_ovf  = 1'b0;
        accept    = prod_valid && (start || state_q == ACCUM);

        // A start-cycle product is term 1 of the fresh dot product.
        if (start) begin
            state_d   = ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_run_d = 1'b0;
            overrun_d = 1'b0;
            base      = '0;
            base_cnt  = '0;
            base_ovf  = 1'b0;
        end

        sum     = base + prod_ext;
        add_ovf = (base[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);

        if (accept) begin
            acc_d     = sum;
            cnt_d     = base_cnt + 8'd1;
            ovf_run_d = base_ovf | add_ovf;
            if (base_cnt + 8'd1 == LAST) begin
                push     = 1'b1;
                push_ovf = base_ovf | add_ovf;
                state_d  = IDLE;
                cnt_d    = '0;
            end
        end

        pop = head_v_q && res_ready;
        if (push && tail_v_q && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        head_d     = head_q;
        head_ovf_d = head_ovf_q;
        head_v_d   = head_v_q;
        tail_d     = tail_q;
        tail_ovf_d = tail_ovf_q;
        tail_v_d   = tail_v_q;

        if (pop) begin
            head_d     = tail_q;
            head_ovf_d = tail_ovf_q;
            head_v_d   = tail_v_q;
            tail_v_d   = 1'b0;
        end

        // The new sum lands in whichever slot is free after this cycle's pop.
        if (push) begin
            if (pop ? !tail_v_q : !head_v_q) begin
                head_d     = sum;
                head_ovf_d = push_ovf;
                head_v_d   = 1'b1;
            end else if (pop || !tail_v_q) begin
                tail_d     = sum;
                tail_ovf_d = push_ovf;
                tail_v_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_run_q  <= 1'b0;
            overrun_q  <= 1'b0;
            head_q     <= '0;
            head_ovf_q <= 1'b0;
            head_v_q   <= 1'b0;
            tail_q     <= '0;
            tail_ovf_q <= 1'b0;
            tail_v_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_run_q  <= ovf_run_d;
            overrun_q  <= overrun_d;
            head_q     <= head_d;
            head_ovf_q <= head_ovf_d;
            head_v_q   <= head_v_d;
            tail_q     <= tail_d;
            tail_ovf_q <= tail_ovf_d;
            tail_v_q   <= tail_v_d;
        end
    end

    assign res_data  = head_q;
    assign res_ovf   = head_ovf_q;
    assign res_valid = head_v_q;
    assign busy      = (state_q == ACCUM);
    assign term_cnt  = cnt_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator: two instances (64-bit/4-term and 72-bit/3-term)
// share stimulus; an arithmetic reference model feeds per-instance expected queues.
module tb_booth_product_accumulator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] prod_in;
    logic        prod_valid;
    logic        res_ready;

    logic [63:0] res_data0;
    logic        res_ovf0, res_valid0, busy0, overrun0, dbg_state0;
    logic [7:0]  term_cnt0;
    logic [71:0] res_data1;
    logic        res_ovf1, res_valid1, busy1, overrun1, dbg_state1;
    logic [7:0]  term_cnt1;

    booth_product_accumulator #(.N_TERMS(4), .ACC_W(64)) dut0 (
        .clk(clk), .reset(reset), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
        .res_data(res_data0), .res_ovf(res_ovf0), .res_valid(res_valid0), .res_ready(res_ready),
        .busy(busy0), .term_cnt(term_cnt0), .overrun(overrun0), .dbg_state(dbg_state0)
    );

    booth_product_accumulator #(.N_TERMS(3), .ACC_W(72)) dut1 (
        .clk(clk), .reset(reset), .start(start), .prod_in(prod_in), .prod_valid(prod_valid),
        .res_data(res_data1), .res_ovf(res_ovf1), .res_valid(res_valid1), .res_ready(res_ready),
        .busy(busy1), .term_cnt(term_cnt1), .overrun(overrun1), .dbg_state(dbg_state1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    bit mon_on   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: index 0 -> dut0, 1 -> dut1
    int                  m_n[2] = '{4, 3};
    int                  m_w[2] = '{64, 72};
    bit                  m_active[2];
    logic signed [127:0] m_acc[2];
    int                  m_cnt[2];
    bit                  m_ovf[2];
    int                  m_occ[2];
    bit                  m_overrun[2];
    logic [72:0]         exp_q0[$];
    logic [72:0]         exp_q1[$];

    task automatic model_step(input int i, input bit rst, input bit st, input bit pv,
                              input logic [63:0] prod, input bit rdy);
        logic signed [127:0] exact, lim, p;
        logic [127:0]        mask;
        logic [72:0]         ent;
        bit                  pop, push, stored;
        if (rst) begin
            m_active[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            m_occ[i] = 0; m_overrun[i] = 0;
            if (i == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        pop    = rdy && (m_occ[i] > 0);
        push   = 0;
        stored = 0;
        if (st) begin
            m_active[i] = 1; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_overrun[i] = 0;
        end
        if (pv && m_active[i]) begin
            p     = {{64{prod[63]}}, prod};
            exact = m_acc[i] + p;
            lim   = 128'sd1 <<< (m_w[i] - 1);
            if (exact >= lim || exact < -lim) m_ovf[i] = 1;
            m_acc[i] = (exact <<< (128 - m_w[i])) >>> (128 - m_w[i]);
            m_cnt[i]++;
            if (m_cnt[i] == m_n[i]) begin
                push = 1;
                m_active[i] = 0;
                m_cnt[i] = 0;
            end
        end
        if (push) begin
            if (m_occ[i] == 2 && !pop) begin
                m_overrun[i] = 1;
            end else begin
                mask   = (128'd1 << m_w[i]) - 128'd1;
                ent    = {m_ovf[i], 72'(m_acc[i] & mask)};
                stored = 1;
                if (i == 0) exp_q0.push_back(ent); else exp_q1.push_back(ent);
            end
        end
        m_occ[i] = m_occ[i] - int'(pop) + int'(stored);
    endtask

    // driver tasks
    task automatic cycle(input bit st, input bit pv, input logic [63:0] prod, input bit rdy);
        @(negedge clk);
        reset = 0; start = st; prod_valid = pv; prod_in = prod; res_ready = rdy;
        for (int i = 0; i < 2; i++) model_step(i, 0, st, pv, prod, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; start = 1; prod_valid = 1; prod_in = 64'd77; res_ready = 1;
        for (int i = 0; i < 2; i++) model_step(i, 1, 0, 0, 0, 0);
    endtask

    task automatic dot(input logic [63:0] a, b, c, d, input bit rdy);
        cycle(1, 0, 64'd0, rdy);
        cycle(0, 1, a, rdy);
        cycle(0, 1, b, rdy);
        cycle(0, 1, c, rdy);
        cycle(0, 1, d, rdy);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // per-cycle state monitor
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_on) begin
            chk("term_cnt0", term_cnt0, m_cnt[0]);
            chk("busy0", busy0, m_active[0]);
            chk("dbg_state0", dbg_state0, m_active[0]);
            chk("overrun0", overrun0, m_overrun[0]);
            chk("res_valid0", res_valid0, m_occ[0] > 0);
            chk("term_cnt1", term_cnt1, m_cnt[1]);
            chk("busy1", busy1, m_active[1]);
            chk("overrun1", overrun1, m_overrun[1]);
            chk("res_valid1", res_valid1, m_occ[1] > 0);
        end
    end

    // scoreboard: compare the head on every accepted transfer
    initial forever begin
        logic [72:0] ent;
        @(negedge clk);
        #1;
        if (mon_on && !reset) begin
            if (res_valid0 && res_ready) begin
                if (exp_q0.size() == 0) chk("sb0_queue_nonempty", 0, 1);
                else begin
                    ent = exp_q0.pop_front();
                    chk("sb0_result", {res_ovf0, 8'd0, res_data0}, ent);
                end
            end
            if (res_valid1 && res_ready) begin
                if (exp_q1.size() == 0) chk("sb1_queue_nonempty", 0, 1);
                else begin
                    ent = exp_q1.pop_front();
                    chk("sb1_result", {res_ovf1, res_data1}, ent);
                end
            end
        end
    end

    initial begin
        logic [63:0] p;
        bit          st;
        reset = 1; start = 0; prod_valid = 0; prod_in = '0; res_ready = 0;
        do_reset();
        mon_on = 1;
        cycle(0, 0, 64'd0, 0);
        settle();
        chk("reset_data0", res_data0, 0);
        chk("reset_ovf0", res_ovf0, 0);

        // basic sum
        dot(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd7, 64'd10, 1);
        settle();
        chk("basic_valid", res_valid0, 1);
        chk("basic_data", res_data0, 15);
        chk("basic_ovf", res_ovf0, 0);
        repeat (3) cycle(0, 0, 64'd0, 1);

        // backpressure and overrun
        dot(64'd1, 0, 0, 0, 0);
        dot(64'd2, 0, 0, 0, 0);
        dot(64'd3, 0, 0, 0, 0);
        settle();
        chk("bp_overrun", overrun0, 1);
        chk("bp_head", res_data0, 1);
        cycle(0, 0, 64'd0, 1);
        settle();
        chk("bp_second", res_data0, 2);
        cycle(0, 0, 64'd0, 1);
        settle();
        chk("bp_empty", res_valid0, 0);

        // overflow
        dot(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1);
        settle();
        chk("ovf_data", res_data0, 64'h8000_0000_0000_0000);
        chk("ovf_flag", res_ovf0, 1);
        dot(64'd1, 64'd1, 0, 0, 1);
        settle();
        chk("ovf_clear_data", res_data0, 2);
        chk("ovf_clear_flag", res_ovf0, 0);

        // restart mid-operation
        cycle(1, 0, 64'd0, 1);
        cycle(0, 1, 64'd5, 1);
        cycle(0, 1, 64'd6, 1);
        cycle(1, 1, 64'd9, 1);
        settle();
        chk("restart_cnt", term_cnt0, 1);
        chk("restart_nopush", res_valid0, 0);
        repeat (3) cycle(0, 1, 64'd1, 1);
        settle();
        chk("restart_sum", res_data0, 12);
        repeat (2) cycle(0, 0, 64'd0, 1);

        // push and pop together when full
        dot(64'd10, 0, 0, 0, 0);
        dot(64'd20, 0, 0, 0, 0);
        cycle(1, 0, 64'd0, 0);
        cycle(0, 1, 64'd30, 0);
        cycle(0, 1, 64'd0, 0);
        cycle(0, 1, 64'd0, 0);
        cycle(0, 1, 64'd0, 1);
        settle();
        chk("full_pp_overrun", overrun0, 0);
        chk("full_pp_head", res_data0, 20);
        cycle(0, 0, 64'd0, 1);
        settle();
        chk("full_pp_tail", res_data0, 30);
        repeat (2) cycle(0, 0, 64'd0, 1);

        // reset with one entry and a partial sum
        dot(64'd4, 0, 0, 0, 0);
        cycle(1, 0, 64'd0, 0);
        cycle(0, 1, 64'd1, 0);
        cycle(0, 1, 64'd1, 0);
        settle();
        chk("pre_reset_cnt", term_cnt0, 2);
        do_reset();
        settle();
        chk("rst_valid", res_valid0, 0);
        chk("rst_data", res_data0, 0);
        chk("rst_ovf", res_ovf0, 0);
        chk("rst_cnt", term_cnt0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_overrun", overrun0, 0);
        repeat (3) cycle(0, 1, {$urandom, $urandom}, 1);
        settle();
        chk("idle_cnt", term_cnt0, 0);
        chk("idle_valid", res_valid0, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0: p = {32'd0, $urandom_range(0, 200)} - 64'd100;
                    1: p = {$urandom, $urandom};
                    2: p = 64'h7FFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
                    default: p = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 255));
                endcase
                st = m_active[0] ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
                cycle(st, $urandom_range(0, 9) < 7, p, $urandom_range(0, 3) != 0);
            end
        end
        repeat (8) cycle(0, 0, 64'd0, 1);
        settle();
        chk("drain_q0", exp_q0.size(), 0);
        chk("drain_q1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream consumer of the Booth multiplier. It takes each 64-bit signed product, qualified by the multiplier's one-cycle output strobe, and sums `N_TERMS` consecutive products into a wider signed accumulator to form a dot product. It flags signed overflow and buffers completed sums in a 2-entry output FIFO with a valid/ready handshake, so the multiplier never has to stall.

## Interface
- `N_TERMS`, default 8: products per dot product; legal range 1..255.
- `ACC_W`, default 72: accumulator and result width; must be at least 64.

- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a new dot product; clears the accumulator and the term count.
- `prod_in`  in  64: signed two's-complement product from the multiplier.
- `prod_valid`  in  1: `prod_in` is valid this cycle; single-cycle strobe.
- `res_data`  out  ACC_W: FIFO head, the completed sum.
- `res_ovf`  out  1: overflow flag of the FIFO head.
- `res_valid`  out  1: FIFO non-empty.
- `res_ready`  in  1: consumer accepts the head this cycle.
- `busy`  out  1: high while in state ACCUM.
- `term_cnt`  out  8: terms accepted in the current dot product.
- `overrun`  out  1: sticky; a completed sum was dropped because the FIFO was full.

## Operation
- States: IDLE, ACCUM.
  - IDLE: `prod_valid` is ignored.
  - `start` moves to ACCUM from either state.
- Start behaviour:
  - `start` sets acc=0, `term_cnt`=0, ovf_run=0, `overrun`=0.
  - If `prod_valid` is high in the same cycle, that product is term 1: acc=sext(`prod_in`), `term_cnt`=1.
- Accumulate, in ACCUM on `prod_valid`:
  - acc ← acc + sext(`prod_in`) to ACC_W; wraps, no saturation.
  - `term_cnt`++.
- Overflow:
  - Signed overflow is detected when both operands have the same sign and the sum sign differs.
  - When detected, ovf_run is set and stays set for the rest of the dot product.
- Completion, on the edge accepting term `N_TERMS`:
  - Push {sum, ovf_run | this add's overflow} into the FIFO.
  - Go to IDLE; `term_cnt` returns to 0.
- `start` mid-ACCUM: partial sum discarded; nothing is pushed; the new dot product begins per the start rule.
- FIFO:
  - 2 entries, in-order.
  - A pop happens when `res_valid` && `res_ready`.
  - Push when full with no simultaneous pop: the sum is dropped, `overrun`=1, FIFO unchanged.
  - Push and pop in the same cycle when full: both take effect; no overrun.
  - Pop when empty: no effect.
- `N_TERMS`=1: every product accepted in ACCUM completes immediately.

## Timing
- Reset values: `res_data`=0, `res_ovf`=0, `res_valid`=0, `busy`=0, `term_cnt`=0, `overrun`=0. FIFO empty, state IDLE.
- Reset overrides `start` and `prod_valid`.
- Reset mid-operation discards the partial sum and all FIFO contents.
- All outputs are registered. The only combinational path is `res_ready` into pop control; there is none to any output.
- Latency:
  - The final term is sampled at edge k.
  - If the FIFO was empty, `res_valid`=1 with the sum from edge k onward, visible in cycle k+1.
  - If one entry is ahead, the new sum appears after that entry is popped.
- `res_data`/`res_ovf` hold stable while `res_valid` && !`res_ready`.
- Back-to-back products on consecutive cycles are supported, at one term per cycle.
- `busy` deasserts at the same edge as the completion push.

## Test plan
- **Basic sum.** `N_TERMS`=4. Pulse `start`, then products 3, -5, 7, 10 with `res_ready`=1.
  - Required: `res_data`=15, `res_ovf`=0, `res_valid` high one cycle after the 4th strobe, `term_cnt` sequence 1,2,3,4→0.
- **Backpressure and overrun.** `res_ready`=0; complete three dot products with sums 1, 2, 3.
  - Required: FIFO holds 1 then 2, `overrun`=1, 3 is lost.
  - Then set `res_ready`=1: outputs 1 then 2, then `res_valid`=0.
- **Overflow.** `ACC_W`=64, `N_TERMS`=2, products 0x7FFF_FFFF_FFFF_FFFF and 1.
  - Required: `res_data`=0x8000_0000_0000_0000, `res_ovf`=1.
  - Next dot product with products 1, 1: `res_data`=2, `res_ovf`=0.
- **Restart mid-operation.** `N_TERMS`=4. After terms 5, 6, assert `start` together with `prod_valid`, product 9.
  - Required: `term_cnt`=1, no push.
  - Then terms 1, 1, 1: `res_data`=12.
- **Simultaneous push/pop when full.** FIFO full with {A, B}. Final term for C arrives while `res_ready`=1.
  - Required: A popped, FIFO holds {B, C}, `overrun` stays 0.
- **Reset and idle.** Assert reset with 1 FIFO entry and `term_cnt`=2.
  - Required: next cycle all outputs 0.
  - Then `prod_valid` pulses without `start`: `term_cnt` stays 0, `res_valid` stays 0.
